// File: rtl/dest_reg_pkg.sv
// Shared encodings for the destination-register tracking pipeline.
// Holds the regdst select codes and the fixed register numbers used by the hazard logic.
package dest_reg_pkg;

    typedef enum logic [1:0] {
        RD_RT   = 2'b00,
        RD_RD   = 2'b01,
        RD_LINK = 2'b10,
        RD_RSVD = 2'b11
    } regdst_e;

    localparam int ZERO_REG     = 0;
    localparam int LINK_REG_DEF = 31;

endpackage

// File: rtl/dest_match.sv
// Youngest-stage match finder for one source register.
// Reports the lowest-indexed stage that will write src, encoded as stage+1 (0 = no match).
module dest_match
    import dest_reg_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3
) (
    input  logic [DEPTH*ADDR_W-1:0] dest_flat,
    input  logic [DEPTH-1:0]        wr_en_vec,
    input  logic [ADDR_W-1:0]       src,
    output logic [3:0]              sel
);

    // Walk from oldest to youngest so the youngest match is the last assignment.
    always_comb begin
        sel = 4'd0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (wr_en_vec[k] && (dest_flat[k*ADDR_W +: ADDR_W] == src) &&
                (src != ADDR_W'(ZERO_REG))) begin
                sel = 4'(k + 1);
            end
        end
    end

endmodule

// File: rtl/dest_reg_pipe.sv
// Tracks the destination register of in-flight instructions across EX/MEM/WB
// and derives forwarding selects and the load-use stall condition from them.
module dest_reg_pipe
    import dest_reg_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              regdst,
    input  logic [ADDR_W-1:0]       rt,
    input  logic [ADDR_W-1:0]       rd,
    input  logic                    regwrite_in,
    input  logic                    memread_in,
    input  logic                    hold,
    input  logic                    bubble,
    input  logic [ADDR_W-1:0]       src_a,
    input  logic [ADDR_W-1:0]       src_b,
    output logic [DEPTH*ADDR_W-1:0] dest_flat,
    output logic [DEPTH-1:0]        wr_en_vec,
    output logic [3:0]              fwd_sel_a,
    output logic [3:0]              fwd_sel_b,
    output logic                    load_use
);

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic              wr_en;
        logic              memread;
    } entry_t;

    entry_t            stage_q [DEPTH];
    entry_t            entry_in;
    logic [ADDR_W-1:0] dest_sel;

    function automatic logic [ADDR_W-1:0] pick_dest(input logic [1:0]        sel,
                                                    input logic [ADDR_W-1:0] rt_f,
                                                    input logic [ADDR_W-1:0] rd_f);
        case (regdst_e'(sel))
            RD_RD:   return rd_f;
            RD_LINK: return ADDR_W'(LINK_REG);
            default: return rt_f;
        endcase
    endfunction

    // A write to register 0 is architecturally a no-op, so it never counts as a producer.
    always_comb begin
        dest_sel         = pick_dest(regdst, rt, rd);
        entry_in.dest    = dest_sel;
        entry_in.wr_en   = regwrite_in && (dest_sel != ADDR_W'(ZERO_REG));
        entry_in.memread = memread_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else if (!hold) begin
            stage_q[0] <= bubble ? entry_t'('0) : entry_in;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign dest_flat[k*ADDR_W +: ADDR_W] = stage_q[k].dest;
        assign wr_en_vec[k]                  = stage_q[k].wr_en;
    end

    dest_match #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_match_a (
        .dest_flat (dest_flat),
        .wr_en_vec (wr_en_vec),
        .src       (src_a),
        .sel       (fwd_sel_a)
    );

    dest_match #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_match_b (
        .dest_flat (dest_flat),
        .wr_en_vec (wr_en_vec),
        .src       (src_b),
        .sel       (fwd_sel_b)
    );

    // A select of 1 means stage 0 is the youngest writer of that source.
    assign load_use = stage_q[0].memread && ((fwd_sel_a == 4'd1) || (fwd_sel_b == 4'd1));

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Directed bench for dest_reg_pipe: default DEPTH=3 instance plus a DEPTH=1 instance
// sharing the same stimulus.
module tb_dest_reg_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  regdst;
    logic [4:0]  rt, rd;
    logic        regwrite_in, memread_in, hold, bubble;
    logic [4:0]  src_a, src_b;
    logic [14:0] dest_flat;
    logic [2:0]  wr_en_vec;
    logic [3:0]  fwd_sel_a, fwd_sel_b;
    logic        load_use;
    logic [4:0]  d1_flat;
    logic [0:0]  d1_wr;
    logic [3:0]  d1_sel_a, d1_sel_b;
    logic        d1_lu;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dest_reg_pipe u_dut (
        .clk(clk), .rst(rst), .regdst(regdst), .rt(rt), .rd(rd),
        .regwrite_in(regwrite_in), .memread_in(memread_in), .hold(hold), .bubble(bubble),
        .src_a(src_a), .src_b(src_b), .dest_flat(dest_flat), .wr_en_vec(wr_en_vec),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .load_use(load_use)
    );

    dest_reg_pipe #(.DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .regdst(regdst), .rt(rt), .rd(rd),
        .regwrite_in(regwrite_in), .memread_in(memread_in), .hold(hold), .bubble(bubble),
        .src_a(src_a), .src_b(src_b), .dest_flat(d1_flat), .wr_en_vec(d1_wr),
        .fwd_sel_a(d1_sel_a), .fwd_sel_b(d1_sel_b), .load_use(d1_lu)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] dst(input int k);
        return dest_flat[k*5 +: 5];
    endfunction

    initial begin
        rst = 1'b1; regdst = 2'b00; rt = '0; rd = '0;
        regwrite_in = 1'b0; memread_in = 1'b0; hold = 1'b0; bubble = 1'b0;
        src_a = 5'd7; src_b = 5'd7;
        step(); step();
        chk("rst_dest", dest_flat, 0);
        chk("rst_wr", wr_en_vec, 0);
        chk("rst_sel_a", fwd_sel_a, 0);
        chk("rst_lu", load_use, 0);
        chk("rst_d1", d1_flat, 0);
        rst = 1'b0;

        // rd=7 travels through all three stages then leaves
        regdst = 2'b01; rd = 5'd7; regwrite_in = 1'b1;
        step();
        chk("p1_dst0", dst(0), 7);
        chk("p1_wr", wr_en_vec, 3'b001);
        chk("p1_sel_a", fwd_sel_a, 1);
        chk("d1_dst", d1_flat, 7);
        chk("d1_sel", d1_sel_a, 1);
        regdst = 2'b00; rd = '0; rt = '0; regwrite_in = 1'b0;
        step();
        chk("p2_flat", dest_flat, 224);
        chk("p2_wr", wr_en_vec, 3'b010);
        chk("p2_sel_a", fwd_sel_a, 2);
        step();
        chk("p3_flat", dest_flat, 7168);
        chk("p3_wr", wr_en_vec, 3'b100);
        chk("p3_sel_a", fwd_sel_a, 3);
        step();
        chk("p4_flat", dest_flat, 0);
        chk("p4_wr", wr_en_vec, 0);

        // link register, then suppressed write to r0, then reserved regdst
        regdst = 2'b10; regwrite_in = 1'b1; src_a = 5'd0; src_b = 5'd31;
        step();
        chk("link_dst0", dst(0), 31);
        chk("link_wr", wr_en_vec, 3'b001);
        regdst = 2'b01; rd = 5'd0;
        step();
        chk("r0_dst0", dst(0), 0);
        chk("r0_wr", wr_en_vec, 3'b010);
        chk("r0_sel_a", fwd_sel_a, 0);
        chk("r0_sel_b", fwd_sel_b, 2);
        regdst = 2'b11; rt = 5'd13; rd = 5'd14;
        step();
        chk("rsvd_dst0", dst(0), 13);
        chk("rsvd_wr", wr_en_vec, 3'b101);

        // youngest-match priority and bubbles
        regdst = 2'b00; src_a = 5'd9; src_b = 5'd5;
        rt = 5'd9; step();
        rt = 5'd5; step();
        rt = 5'd9; step();
        chk("yng_sel_a", fwd_sel_a, 1);
        chk("yng_sel_b", fwd_sel_b, 2);
        chk("yng_lu", load_use, 0);
        chk("d1_yng", d1_sel_a, 1);
        bubble = 1'b1;
        step();
        chk("bub1_dst0", dst(0), 0);
        chk("bub1_sel_a", fwd_sel_a, 2);
        chk("bub1_sel_b", fwd_sel_b, 3);
        chk("d1_bub", d1_sel_a, 0);
        step();
        chk("bub2_sel_a", fwd_sel_a, 3);
        chk("bub2_sel_b", fwd_sel_b, 0);
        bubble = 1'b0; regwrite_in = 1'b0;
        step();
        chk("nowr_dst0", dst(0), 9);
        chk("nowr_wr", wr_en_vec, 0);
        chk("nowr_sel_a", fwd_sel_a, 0);

        // load-use detection
        rt = 5'd4; memread_in = 1'b1; regwrite_in = 1'b1; src_a = 5'd1; src_b = 5'd4;
        step();
        chk("ld_lu", load_use, 1);
        chk("ld_sel_b", fwd_sel_b, 1);
        chk("d1_lu", d1_lu, 1);
        bubble = 1'b1; memread_in = 1'b0;
        step();
        chk("ldb_lu", load_use, 0);
        chk("ldb_dst1", dst(1), 4);
        chk("ldb_sel_b", fwd_sel_b, 2);
        bubble = 1'b0; memread_in = 1'b1; regwrite_in = 1'b0;
        step();
        chk("ldnw_lu", load_use, 0);
        chk("ldnw_sel_b", fwd_sel_b, 3);
        memread_in = 1'b0; regwrite_in = 1'b1;
        step();
        chk("alu_lu", load_use, 0);
        chk("alu_sel_b", fwd_sel_b, 1);
        rt = 5'd1; memread_in = 1'b1;
        step();
        chk("lda_lu", load_use, 1);

        // fill three valid entries: 11, 12, link (load)
        memread_in = 1'b0; regdst = 2'b00; rt = 5'd11; step();
        regdst = 2'b01; rd = 5'd12; step();
        regdst = 2'b10; memread_in = 1'b1; src_a = 5'd12; src_b = 5'd31; step();
        chk("fill_flat", dest_flat, 11679);
        chk("fill_wr", wr_en_vec, 3'b111);
        chk("fill_sel_a", fwd_sel_a, 2);
        chk("fill_sel_b", fwd_sel_b, 1);
        chk("fill_lu", load_use, 1);

        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rt = 5'(i + 20); rd = 5'(i + 1); regdst = 2'(i);
            bubble = i[0]; memread_in = i[0];
            step();
            chk("hold_flat", dest_flat, 11679);
            chk("hold_wr", wr_en_vec, 3'b111);
            chk("hold_lu", load_use, 1);
        end
        bubble = 1'b1;
        step();
        chk("holdb_flat", dest_flat, 11679);
        chk("holdb_sel_a", fwd_sel_a, 2);
        chk("holdb_d1", d1_flat, 31);

        // asynchronous reset between edges
        #3 rst = 1'b1;
        #1;
        chk("arst_flat", dest_flat, 0);
        chk("arst_wr", wr_en_vec, 0);
        chk("arst_sel_a", fwd_sel_a, 0);
        chk("arst_sel_b", fwd_sel_b, 0);
        chk("arst_lu", load_use, 0);
        chk("arst_d1", d1_flat, 0);
        hold = 1'b0; bubble = 1'b0; regdst = 2'b00; rt = 5'd6;
        regwrite_in = 1'b1; memread_in = 1'b0;
        #2 rst = 1'b0;
        step();
        chk("post_dst0", dst(0), 6);
        chk("post_wr", wr_en_vec, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
